// File: rtl/rv32im_dmem_responder.sv
// ---------------------------------------------------------------------------
// rv32im_dmem_responder
//
// Memory-side responder for the rv32im LSU data port. Accepts one load/store
// at a time, holds it for LATENCY wait states, performs it on an internal
// word RAM and returns a single-cycle response. The full 32-bit word is
// returned; byte/half extraction and sign extension are left to the LSU.
//
// Handshake (valid/ready):
//   A request transfers on a rising edge where req_i && ready_o. ready_o is
//   high only in IDLE. req_i seen while ready_o=0 is ignored, so the LSU holds
//   req_i and its fields stable until it sees ready_o. After transfer, the
//   fields are taken from an internal latched copy. The response is a single
//   rvalid_o pulse exactly LATENCY+2 cycles after the transfer edge; ready_o
//   is already high in that same cycle. rdata_o and err_o are 0 whenever
//   rvalid_o is 0. There is no back-pressure on the response.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      wait-state cycles between acceptance and response (0..15)
//
// Configuration macro:
//   DMEM_ERR_EN  when defined, out-of-range word indices and illegal byte
//                strobe patterns are rejected with err_o=1 and no RAM write.
//                When undefined, err_o is 0, the word index wraps modulo
//                DEPTH_WORDS and any strobe pattern is applied as given.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset (priority over req_i)
//   req_i        request valid
//   we_i         1 = store, 0 = load
//   be_i[3:0]    byte strobes, bit n selects bits 8n+7:8n
//   addr_i[31:0] byte address, word index = addr_i[31:2]
//   wdata_i      lane-aligned store data
//   ready_o      responder idle
//   rvalid_o     one-cycle response strobe
//   rdata_o      load data (0 for stores, errors and when rvalid_o=0)
//   err_o        request rejected (qualified by rvalid_o)
//   dbg_state_o  current FSM state (IDLE=0, WAIT=1, RESP=2)
// ---------------------------------------------------------------------------
module rv32im_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter preload on acceptance; WAIT lasts WAIT_INIT+1 = LATENCY cycles.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  // Latched request fields
  logic        we_q;
  logic [3:0]  be_q;
  logic [29:0] widx_q;
  logic [31:0] wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          req_bad;
  logic          do_write;
  logic          err_q;

  // Address byte offset is never used; upper index bits only matter for the
  // range check.
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], widx_q};

  assign ram_idx     = widx_q[AW-1:0];
  assign ready_o     = (state_q == IDLE);
  assign dbg_state_o = state_q;

  // -------------------------------------------------------------------------
  // Request legality
  // -------------------------------------------------------------------------
`ifdef DMEM_ERR_EN
  logic be_legal;
  logic out_of_range;

  always_comb begin
    be_legal = 1'b0;
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      4'b0000:                   be_legal = we_q;  // empty store is a no-op, empty load is an error
      default:                   be_legal = 1'b0;
    endcase
  end

  assign out_of_range = ({2'b00, widx_q} >= 32'(DEPTH_WORDS));
  assign req_bad      = out_of_range || !be_legal;
  assign err_o        = err_q;
`else
  assign req_bad = 1'b0;
  assign err_o   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch: only written on the transfer edge, so later input changes
  // cannot disturb an in-flight access.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (accept && !rst_i) begin
      we_q    <= we_i;
      be_q    <= be_i;
      widx_q  <= addr_i[31:2];
      wdata_q <= wdata_i;
    end
  end

  // -------------------------------------------------------------------------
  // RAM: not reset. A reset in RESP suppresses the write.
  // -------------------------------------------------------------------------
  assign do_write = (state_q == RESP) && we_q && !req_bad && !rst_i;

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) mem[ram_idx][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response register: one-cycle strobe after RESP, data/err zero otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_q    <= 1'b0;
    end else if (state_q == RESP) begin
      rvalid_o <= 1'b1;
      rdata_o  <= (!we_q && !req_bad) ? mem[ram_idx] : 32'd0;
      err_q    <= req_bad;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32im_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_rv32im_dmem_responder
//
// Directed bench for rv32im_dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
// A transaction-level model keeps a sparse word memory and a queue of
// in-flight requests with their acceptance and due cycles; a per-cycle
// compare process checks ready_o/rvalid_o/rdata_o/err_o against it. Directed
// transfers additionally carry hand-computed literal expectations.
// Works with and without DMEM_ERR_EN.
// ---------------------------------------------------------------------------
module tb_rv32im_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clk     = 1'b0;
  logic        rst_i   = 1'b1;
  logic        req_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic [3:0]  be_i    = 4'd0;
  logic [31:0] addr_i  = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        ready_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  rv32im_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .dbg_state_o(dbg_state)
  );

  int cyc       = 0;
  int errors    = 0;
  int checks    = 0;
  int pulse_cnt = 0;
  bit chk_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Model
  // -------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
    int          due;
  } txn_t;

  txn_t        pend_q[$];
  logic [31:0] mm [int unsigned];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Responder is busy strictly between an acceptance cycle and its response cycle.
  function automatic bit model_busy(input int c);
    foreach (pend_q[i]) if (pend_q[i].acc < c && c < pend_q[i].due) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_resp(input txn_t t);
    int unsigned widx;
    int unsigned idx;
    bit          bad;
    logic [31:0] w;
    widx = 32'(t.addr[31:2]);
    bad  = 1'b0;
`ifdef DMEM_ERR_EN
    bad = (widx >= DEPTH) ||
          !((t.be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) || (t.we && t.be == 4'h0));
    idx = widx;
`else
    idx = widx % DEPTH;
`endif
    check("sb_err", 32'(err_o), 32'(bad));
    if (bad || t.we) check("sb_rdata_zero", rdata_o, 32'd0);
    else if (mm.exists(idx)) check("sb_rdata", rdata_o, mm[idx]);
    if (t.we && !bad && (mm.exists(idx) || t.be == 4'hF)) begin
      w = mm.exists(idx) ? mm[idx] : 32'd0;
      for (int n = 0; n < 4; n++) if (t.be[n]) w[8*n +: 8] = t.wdata[8*n +: 8];
      mm[idx] = w;
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard compare, every cycle on the falling edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    bit   due_now;
    txn_t t;
    if (chk_en) begin
      due_now = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      check("sb_ready", 32'(ready_o), 32'(!model_busy(cyc)));
      check("sb_rvalid", 32'(rvalid_o), 32'(due_now));
      if (rvalid_o) pulse_cnt++;
      if (due_now) begin
        t = pend_q.pop_front();
        model_resp(t);
      end else begin
        check("sb_rdata_idle", rdata_o, 32'd0);
        check("sb_err_idle", 32'(err_o), 32'd0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (entered and left 1 time unit after a rising edge)
  // -------------------------------------------------------------------------
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
    txn_t t;
    we_i = we; be_i = be; addr_i = addr; wdata_i = wdata; req_i = 1'b1;
    for (int i = 0; i < 50 && model_busy(cyc); i++) begin
      @(posedge clk); #1;
    end
    acc = cyc;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    t.acc = cyc; t.due = cyc + LAT + 2;
    pend_q.push_back(t);
    @(posedge clk); #1;
    // Scramble the fields after transfer; the latched copy must be used.
    req_i   = 1'b0;
    we_i    = 1'($urandom_range(0, 1));
    be_i    = 4'($urandom_range(0, 15));
    addr_i  = $urandom;
    wdata_i = $urandom;
  endtask

  task automatic wait_resp(input string name, input logic [31:0] exp_rdata,
                           input logic exp_err, input int acc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rvalid_o) begin
        seen = 1'b1;
        check({name, "_latency"}, 32'(cyc - acc), 32'd4);
        check({name, "_rdata"}, rdata_o, exp_rdata);
        check({name, "_err"}, 32'(err_o), 32'(exp_err));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no rvalid_o within 30 cycles, state=%0d", name, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic xfer(input string name, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int a;
    issue(we, be, addr, wdata, a);
    wait_resp(name, exp_rdata, exp_err, a);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int a0, a1, p;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_rvalid", 32'(rvalid_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    chk_en = 1'b1;

    // Full-word store then load back
    xfer("st_full", 1'b1, 4'hF, 32'h10, 32'h000CF5BD, 32'h0, 1'b0);
    xfer("ld_full", 1'b0, 4'hF, 32'h10, 32'h0,        32'h000CF5BD, 1'b0);

    // Byte lane 1 store merges into the existing word
    xfer("st_byte1", 1'b1, 4'b0010, 32'h10, 32'h0000AA00, 32'h0, 1'b0);
    xfer("ld_byte1", 1'b0, 4'hF,    32'h10, 32'h0,        32'h000CAABD, 1'b0);

    // Low address bits are ignored
    xfer("st_40", 1'b1, 4'hF, 32'h40, 32'h12345678, 32'h0, 1'b0);
    xfer("ld_43", 1'b0, 4'hF, 32'h43, 32'h0,        32'h12345678, 1'b0);

    // Request held during WAIT is ignored until ready_o returns
    p = pulse_cnt;
    issue(1'b1, 4'hF, 32'h44, 32'hCAFEF00D, a0);
    issue(1'b0, 4'hF, 32'h40, 32'h0, a1);
    wait_resp("held_ld", 32'h12345678, 1'b0, a1);
    check("held_pulses", 32'(pulse_cnt - p), 32'd2);
    xfer("ld_44", 1'b0, 4'hF, 32'h44, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT drops the store
    p = pulse_cnt;
    issue(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, a0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    pend_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_pulse", 32'(pulse_cnt - p), 32'd0);
    xfer("ld_after_rst", 1'b0, 4'hF, 32'h40, 32'h0, 32'h12345678, 1'b0);

    // Empty-strobe store: normal response, no change
    xfer("st_be0", 1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b0);
    xfer("ld_be0", 1'b0, 4'hF,    32'h40, 32'h0,        32'h12345678, 1'b0);

    // Upper halfword store
    xfer("st_half", 1'b1, 4'b1100, 32'h40, 32'hBEEF0000, 32'h0, 1'b0);
    xfer("ld_half", 1'b0, 4'hF,    32'h40, 32'h0,        32'hBEEF5678, 1'b0);

    // Last word and word 0
    xfer("st_last", 1'b1, 4'hF, 32'hFFC, 32'h5A5AA5A5, 32'h0, 1'b0);
    xfer("ld_last", 1'b0, 4'hF, 32'hFFC, 32'h0,        32'h5A5AA5A5, 1'b0);
    xfer("st_w0",   1'b1, 4'hF, 32'h0,   32'h0BADF00D, 32'h0, 1'b0);

`ifdef DMEM_ERR_EN
    xfer("ld_oor",    1'b0, 4'hF,    32'h1000, 32'h0,        32'h0, 1'b1);
    xfer("st_oor",    1'b1, 4'hF,    32'h1000, 32'h11111111, 32'h0, 1'b1);
    xfer("ld_w0",     1'b0, 4'hF,    32'h0,    32'h0,        32'h0BADF00D, 1'b0);
    xfer("st_be0110", 1'b1, 4'b0110, 32'h40,   32'h0,        32'h0, 1'b1);
    xfer("ld_be0110", 1'b0, 4'hF,    32'h40,   32'h0,        32'hBEEF5678, 1'b0);
    xfer("ld_be0",    1'b0, 4'b0000, 32'h40,   32'h0,        32'h0, 1'b1);
`else
    xfer("ld_wrap",   1'b0, 4'hF,    32'h1000, 32'h0,        32'h0BADF00D, 1'b0);
    xfer("st_48",     1'b1, 4'hF,    32'h48,   32'hFFFFFFFF, 32'h0, 1'b0);
    xfer("st_be0110", 1'b1, 4'b0110, 32'h48,   32'h11223344, 32'h0, 1'b0);
    xfer("ld_be0110", 1'b0, 4'hF,    32'h48,   32'h0,        32'hFF2233FF, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, state=%0d", dbg_state);
    $fatal(1, "watchdog expired");
  end

endmodule
